// File: rtl/hnf_txreq_arb_pkg.sv
// Shared HN-F TXREQ definitions: request flit layout, opcodes, FSM states.
package hnf_txreq_arb_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [5:0]  opcode;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [5:0]  REQ_OPC_LCRDRETURN = 6'h00;
  localparam int unsigned LCRD_MAX_DEFAULT   = 15;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    RETURN
  } hnf_txreq_state_e;

  // Link-layer credit return flit: all fields zero apart from the opcode.
  function automatic reqflit_t lcrd_return_flit();
    reqflit_t f;
    f        = '0;
    f.opcode = REQ_OPC_LCRDRETURN;
    f.txnid  = 8'h00;
    return f;
  endfunction

endpackage

// File: rtl/hnf_txreq_arb_if.sv
// TXREQ channel bundle: requester handshakes, link pins and status.
interface hnf_txreq_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CRD_W   = 4
);
  import hnf_txreq_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  reqflit_t [NUM_REQ-1:0]        req_flit;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          link_en;
  reqflit_t                      TXREQFLIT;
  logic                          TXREQFLITV;
  logic                          TXREQFLITPEND;
  logic                          TXREQLCRDV;
  logic                          link_idle;
  logic [CRD_W-1:0]              lcrd_cnt;
  logic                          crd_overflow;

  // Requesters + link receiver + control.
  modport master (
    output req_valid, req_flit, link_en, TXREQLCRDV,
    input  req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND,
           link_idle, lcrd_cnt, crd_overflow
  );

  // The arbiter/controller.
  modport slave (
    input  req_valid, req_flit, link_en, TXREQLCRDV,
    output req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND,
           link_idle, lcrd_cnt, crd_overflow
  );

endinterface

// File: rtl/hnf_txreq_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Scan from ptr upward modulo NUM_REQ; first hit wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (en && (gnt == '0) && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/hnf_txreq_arb.sv
// HN-F TXREQ controller: round-robin request arbitration, L-credit
// accounting and link deactivation by returning held credits.
module hnf_txreq_arb
  import hnf_txreq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_LCRD = LCRD_MAX_DEFAULT,
  parameter int unsigned CRD_W    = $clog2(MAX_LCRD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  hnf_txreq_arb_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  hnf_txreq_state_e   state_q, state_d;
  logic [CRD_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               flitv_q;
  reqflit_t           flit_q, flit_d;
  logic               pend_q;
  logic               ovf_q, ovf_set;

  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               grant, ret, send;

  // Requesters are only served while running with link_en still high and
  // a credit in hand; a falling link_en freezes them out in the same cycle.
  assign arb_en = (state_q == RUN) && bus.link_en && (cnt_q != '0);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant = |gnt;
  assign ret   = (state_q == RETURN) && (cnt_q != '0);
  assign send  = grant | ret;

  // Link state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP:    if (bus.link_en)  state_d = RUN;
      RUN:     if (!bus.link_en) state_d = RETURN;
      RETURN:  if ((cnt_q == '0) && !bus.TXREQLCRDV) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // Credit count, overflow detection, pointer advance and launch flit.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    rr_d    = rr_q;
    flit_d  = grant ? bus.req_flit[gnt_idx] : lcrd_return_flit();
    if (bus.TXREQLCRDV && !send) begin
      if (cnt_q == CRD_W'(MAX_LCRD)) ovf_set = 1'b1;
      else                           cnt_d   = cnt_q + CRD_W'(1);
    end else if (!bus.TXREQLCRDV && send) begin
      cnt_d = cnt_q - CRD_W'(1);
    end
    if (grant) begin
      rr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // State, counters and the registered link outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= STOP;
      cnt_q   <= '0;
      rr_q    <= '0;
      flitv_q <= 1'b0;
      flit_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      flitv_q <= send;
      if (send) flit_q <= flit_d;
      pend_q  <= (state_d != STOP);
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign bus.req_ready     = gnt;
  assign bus.TXREQFLIT     = flit_q;
  assign bus.TXREQFLITV    = flitv_q;
  assign bus.TXREQFLITPEND = pend_q;
  assign bus.link_idle     = (state_q == STOP) && (cnt_q == '0);
  assign bus.lcrd_cnt      = cnt_q;
  assign bus.crd_overflow  = ovf_q;

endmodule

// File: tb/tb_hnf_txreq_arb.sv
// Bench for hnf_txreq_arb: per-cycle vector table with hand-derived
// expectations, flit scoreboard, and a mid-operation reset sequence.
module tb_hnf_txreq_arb;
  import hnf_txreq_arb_pkg::*;

  logic clock;
  logic reset;

  hnf_txreq_arb_if #(.NUM_REQ(2), .CRD_W(4)) bus ();

  hnf_txreq_arb #(
    .NUM_REQ  (2),
    .MAX_LCRD (15),
    .CRD_W    (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit       le;
    bit       crd;
    bit [1:0] rv;
    bit [1:0] rdy;
    int       cnt;
    bit       ret;
    bit       pend;
    bit       idle;
    bit       ovf;
  } row_t;

  row_t     tbl[$];
  reqflit_t sb[$];
  reqflit_t last_flit;
  int       n_pass  = 0;
  int       n_total = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void add(bit le, bit crd, bit [1:0] rv, bit [1:0] rdy, int cnt,
                              bit ret, bit pend, bit idle, bit ovf);
    row_t r;
    r.le = le; r.crd = crd; r.rv = rv; r.rdy = rdy; r.cnt = cnt;
    r.ret = ret; r.pend = pend; r.idle = idle; r.ovf = ovf;
    tbl.push_back(r);
  endfunction

  // Flit monitor: every valid flit must match the scoreboard head;
  // while idle the link flit must hold its previous value.
  always @(negedge clock) begin
    if (!reset) begin
      last_flit = '0;
    end else if (bus.TXREQFLITV) begin
      if (sb.size() == 0) begin
        chk("unexpected_flit", 128'(bus.TXREQFLIT), 128'(1'b0));
      end else begin
        chk("flit", 128'(bus.TXREQFLIT), 128'(sb[0]));
        void'(sb.pop_front());
      end
      last_flit = bus.TXREQFLIT;
    end else begin
      chk("flit_hold", 128'(bus.TXREQFLIT), 128'(last_flit));
    end
  end

  // Drive one table row at a negedge, check the combinational grant,
  // queue expected flits, then check registered state after the edge.
  task automatic apply(input row_t r, input int idx);
    reqflit_t f;
    bus.link_en    = r.le;
    bus.TXREQLCRDV = r.crd;
    bus.req_valid  = r.rv;
    for (int i = 0; i < 2; i++) begin
      f        = '0;
      f.opcode = 6'h04;
      f.srcid  = 7'(i + 1);
      f.txnid  = 8'(idx * 2 + i);
      f.addr   = 48'(idx * 64 + i * 8);
      bus.req_flit[i] = f;
    end
    #2;
    chk($sformatf("req_ready[%0d]", idx), 128'(bus.req_ready), 128'(r.rdy));
    if (r.rdy == 2'b01) sb.push_back(bus.req_flit[0]);
    if (r.rdy == 2'b10) sb.push_back(bus.req_flit[1]);
    if (r.ret)          sb.push_back(lcrd_return_flit());
    @(posedge clock);
    #1;
    chk($sformatf("lcrd_cnt[%0d]", idx),  128'(bus.lcrd_cnt),      128'(r.cnt));
    chk($sformatf("pend[%0d]", idx),      128'(bus.TXREQFLITPEND), 128'(r.pend));
    chk($sformatf("link_idle[%0d]", idx), 128'(bus.link_idle),     128'(r.idle));
    chk($sformatf("overflow[%0d]", idx),  128'(bus.crd_overflow),  128'(r.ovf));
    @(negedge clock);
  endtask

  initial begin
    // Test 1: three credits, requester 0 only.
    add(1,0,2'b01,2'b00,0,0,1,0,0);
    add(1,1,2'b01,2'b00,1,0,1,0,0);
    add(1,1,2'b01,2'b01,1,0,1,0,0);
    add(1,1,2'b01,2'b01,1,0,1,0,0);
    add(1,0,2'b01,2'b01,0,0,1,0,0);
    add(1,0,2'b01,2'b00,0,0,1,0,0);
    // Realign pointer to 0 via one req1 grant, then bank 4 credits.
    add(1,1,2'b00,2'b00,1,0,1,0,0);
    add(1,1,2'b10,2'b10,1,0,1,0,0);
    add(1,1,2'b00,2'b00,2,0,1,0,0);
    add(1,1,2'b00,2'b00,3,0,1,0,0);
    add(1,1,2'b00,2'b00,4,0,1,0,0);
    // Test 2: both valid, alternation 0,1,0,1.
    add(1,0,2'b11,2'b01,3,0,1,0,0);
    add(1,0,2'b11,2'b10,2,0,1,0,0);
    add(1,0,2'b11,2'b01,1,0,1,0,0);
    add(1,0,2'b11,2'b10,0,0,1,0,0);
    add(1,0,2'b11,2'b00,0,0,1,0,0);
    // Test 3: credit and send in the same cycle.
    add(1,1,2'b00,2'b00,1,0,1,0,0);
    add(1,1,2'b00,2'b00,2,0,1,0,0);
    add(1,1,2'b01,2'b01,2,0,1,0,0);
    add(1,0,2'b01,2'b01,1,0,1,0,0);
    add(1,1,2'b01,2'b01,1,0,1,0,0);
    add(1,0,2'b01,2'b01,0,0,1,0,0);
    add(1,0,2'b01,2'b00,0,0,1,0,0);
    // Test 4: fill to 15, 16th credit overflows and sticks.
    for (int k = 1; k <= 15; k++) add(1,1,2'b00,2'b00,k,0,1,0,0);
    add(1,1,2'b00,2'b00,15,0,1,0,1);
    add(1,0,2'b00,2'b00,15,0,1,0,1);
    for (int k = 14; k >= 3; k--) add(1,0,2'b01,2'b01,k,0,1,0,1);
    // Test 5: deactivate with 3 credits; one arrives mid-return;
    // link_en bouncing high in RETURN is ignored.
    add(0,0,2'b11,2'b00,3,0,1,0,1);
    add(0,0,2'b11,2'b00,2,1,1,0,1);
    add(0,1,2'b11,2'b00,2,1,1,0,1);
    add(1,0,2'b11,2'b00,1,1,1,0,1);
    add(0,0,2'b11,2'b00,0,1,1,0,1);
    add(0,0,2'b11,2'b00,0,0,0,1,1);
    add(0,0,2'b11,2'b00,0,0,0,1,1);
    // Test 6 setup: restart, bank 5 credits, launch one flit.
    add(1,1,2'b00,2'b00,1,0,1,0,1);
    for (int k = 2; k <= 5; k++) add(1,1,2'b00,2'b00,k,0,1,0,1);
    add(1,1,2'b10,2'b10,5,0,1,0,1);

    bus.link_en    = 1'b0;
    bus.TXREQLCRDV = 1'b0;
    bus.req_valid  = '0;
    bus.req_flit   = '0;
    last_flit      = '0;
    reset          = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_flitv",  128'(bus.TXREQFLITV),    128'(0));
    chk("rst_flit",   128'(bus.TXREQFLIT),     128'(0));
    chk("rst_cnt",    128'(bus.lcrd_cnt),      128'(0));
    chk("rst_pend",   128'(bus.TXREQFLITPEND), 128'(0));
    chk("rst_ovf",    128'(bus.crd_overflow),  128'(0));
    chk("rst_ready",  128'(bus.req_ready),     128'(0));
    chk("rst_idle",   128'(bus.link_idle),     128'(1));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Test 6: asynchronous reset while a flit is on the link.
    #2;
    chk("pre_flitv", 128'(bus.TXREQFLITV), 128'(1));
    chk("pre_cnt",   128'(bus.lcrd_cnt),   128'(5));
    bus.link_en    = 1'b0;
    bus.TXREQLCRDV = 1'b0;
    bus.req_valid  = '0;
    reset = 1'b0;
    #1;
    chk("arst_flitv", 128'(bus.TXREQFLITV),    128'(0));
    chk("arst_flit",  128'(bus.TXREQFLIT),     128'(0));
    chk("arst_cnt",   128'(bus.lcrd_cnt),      128'(0));
    chk("arst_idle",  128'(bus.link_idle),     128'(1));
    chk("arst_pend",  128'(bus.TXREQFLITPEND), 128'(0));
    chk("arst_ovf",   128'(bus.crd_overflow),  128'(0));
    chk("arst_ready", 128'(bus.req_ready),     128'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_cnt",  128'(bus.lcrd_cnt),   128'(0));
    chk("post_idle", 128'(bus.link_idle),  128'(1));
    chk("post_flitv",128'(bus.TXREQFLITV), 128'(0));
    chk("sb_empty",  128'(sb.size()),      128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
